// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared definitions for the issue-hazard scoreboard.
//   REG_WIDTH : architectural register address width (x0..x(2**REG_WIDTH-1))
//   SB_CNT_W  : default width of each per-register pending-write counter
//   sb_src_t  : one decode source operand (register address + "is read" flag)
package ysyx_24080006_pkg;

  localparam int REG_WIDTH = 4;
  localparam int SB_CNT_W  = 2;

  typedef struct packed {
    logic [REG_WIDTH-1:0] addr;
    logic                 used;
  } sb_src_t;

endpackage

// File: rtl/ysyx_24080006_sb_cnt.sv
// ysyx_24080006_sb_cnt: pending-write counter for one architectural register.
//   clock, reset  : clock, asynchronous active-high reset
//   flush         : clear the counter on the next edge (wins over inc/dec)
//   inc           : an instruction writing this register issues this cycle
//   wb_hit        : writeback targets this register this cycle
//   cnt           : current pending count (registered)
//   pending_next  : next-state count is non-zero (feeds the registered busy flag)
module ysyx_24080006_sb_cnt
  import ysyx_24080006_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic             wb_hit,
  output logic [CNT_W-1:0] cnt,
  output logic             pending_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             dec_s;

  // A writeback only retires something when a write is actually pending.
  assign dec_s = wb_hit & (cnt_r != {CNT_W{1'b0}});

  // Next-state selection; simultaneous issue and retire cancel out.
  always_comb begin
    cnt_next_s = cnt_r;
    if (flush) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (inc && !dec_s) begin
      if (cnt_r != CNT_MAX) begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
    end else if (dec_s && !inc) begin
      cnt_next_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt          = cnt_r;
  assign pending_next = (cnt_next_s != {CNT_W{1'b0}});

endmodule

// File: rtl/ysyx_24080006_scoreboard.sv
// ysyx_24080006_scoreboard: issue-hazard controller between decode and execute.
//   clock, reset              : clock, asynchronous active-high reset
//   id_valid                  : decode holds an instruction ready to issue
//   id_rs1_addr/used          : source 1 address / instruction reads it
//   id_rs2_addr/used          : source 2 address / instruction reads it
//   id_rd_addr/we             : destination address / instruction writes it
//   exu_ready                 : execute accepts an instruction this cycle
//   issue_ready (comb)        : no RAW hazard, no counter saturation, no flush
//   issue_fire  (comb)        : id_valid & issue_ready & exu_ready
//   wb_valid, wb_rd_addr      : writeback retires one register write
//   flush                     : discard all in-flight tracking
//   busy        (reg)         : some register has a pending write
//   sb_err      (reg, sticky) : writeback hit a register with nothing pending
//   stall_cnt   (reg)         : cycles decode was held by the scoreboard
module ysyx_24080006_scoreboard
  import ysyx_24080006_pkg::*;
#(
  parameter int CNT_W     = SB_CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_WIDTH-1:0] id_rs1_addr,
  input  logic                 id_rs1_used,
  input  logic [REG_WIDTH-1:0] id_rs2_addr,
  input  logic                 id_rs2_used,
  input  logic [REG_WIDTH-1:0] id_rd_addr,
  input  logic                 id_rd_we,
  input  logic                 exu_ready,
  output logic                 issue_ready,
  output logic                 issue_fire,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd_addr,
  input  logic                 flush,
  output logic                 busy,
  output logic                 sb_err,
  output logic [31:0]          stall_cnt
);

  localparam int               NUM_REGS = 2 ** REG_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] pend_next_s;
  sb_src_t             rs1_s;
  sb_src_t             rs2_s;
  logic                hazard_rs1_s;
  logic                hazard_rs2_s;
  logic                saturated_s;
  logic                sb_err_set_s;
  logic                stall_s;
  logic                busy_r;
  logic                sb_err_r;
  logic [31:0]         stall_cnt_r;

  // A source is pending when its count, less a bypassed same-cycle writeback, is non-zero.
  function automatic logic src_hazard(input sb_src_t src, input logic [CNT_W-1:0] cnt,
                                      input logic wb_v, input logic [REG_WIDTH-1:0] wb_a);
    logic [CNT_W-1:0] eff;
    eff = cnt - CNT_W'(WB_BYPASS & wb_v & (wb_a == src.addr));
    return src.used & (src.addr != {REG_WIDTH{1'b0}}) & (eff != {CNT_W{1'b0}});
  endfunction

  assign rs1_s = '{addr: id_rs1_addr, used: id_rs1_used};
  assign rs2_s = '{addr: id_rs2_addr, used: id_rs2_used};

  // x0 is never tracked.
  assign cnt_s[0]       = {CNT_W{1'b0}};
  assign pend_next_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    ysyx_24080006_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .inc          (issue_fire & id_rd_we & (id_rd_addr == REG_WIDTH'(r))),
      .wb_hit       (wb_valid & (wb_rd_addr == REG_WIDTH'(r))),
      .cnt          (cnt_s[r]),
      .pending_next (pend_next_s[r])
    );
  end

  // Issue gating: RAW hazards on either source, or destination counter would overflow.
  always_comb begin
    hazard_rs1_s = src_hazard(rs1_s, cnt_s[id_rs1_addr], wb_valid, wb_rd_addr);
    hazard_rs2_s = src_hazard(rs2_s, cnt_s[id_rs2_addr], wb_valid, wb_rd_addr);
    if (id_rd_we && (id_rd_addr != {REG_WIDTH{1'b0}}) && (cnt_s[id_rd_addr] == CNT_MAX)) begin
      saturated_s = !(wb_valid && (wb_rd_addr == id_rd_addr));
    end else begin
      saturated_s = 1'b0;
    end
  end

  assign issue_ready = !flush & !hazard_rs1_s & !hazard_rs2_s & !saturated_s;
  assign issue_fire  = id_valid & issue_ready & exu_ready;

  // Retiring a write nobody issued is an error; flush cycles and x0 are exempt.
  assign sb_err_set_s = wb_valid & !flush & (wb_rd_addr != {REG_WIDTH{1'b0}}) &
                        (cnt_s[wb_rd_addr] == {CNT_W{1'b0}});
  assign stall_s      = id_valid & exu_ready & !issue_ready;

  // Status registers: busy tracks next-state counters, sb_err is sticky, stall_cnt wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r      <= 1'b0;
      sb_err_r    <= 1'b0;
      stall_cnt_r <= 32'd0;
    end else begin
      busy_r   <= |pend_next_s;
      sb_err_r <= sb_err_r | sb_err_set_s;
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign busy      = busy_r;
  assign sb_err    = sb_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule
